// File: rtl/ram_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ram_responder
//  Purpose  : Memory-side responder for a request/response RAM handshake.
//             Owns a DEPTH-word RAM, services one request at a time and
//             returns one in-order response per accepted request, with a
//             fixed read latency and full response backpressure.
//  Revision : 1.0  initial release
// ============================================================================
module ram_responder #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_write,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  busy
);

  localparam int DEPTH   = 2 ** ADDR_WIDTH;
  localparam int C_CNT_W = 4;
  localparam logic [C_CNT_W-1:0] C_LAT_M1 = C_CNT_W'(READ_LATENCY - 1);

  // Latency counter is sized for the largest legal latency (8 -> cnt 7).
  generate
    if (READ_LATENCY < 1 || READ_LATENCY > 8) begin : g_bad_latency
      $error("ram_responder: READ_LATENCY must be in 1..8");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                r_state;
  logic [C_CNT_W-1:0]    r_cnt;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_write;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_accept;

  assign w_accept   = req_valid && r_req_ready;
  assign req_ready  = r_req_ready;
  assign busy       = ~r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_write = r_resp_write;
  assign resp_rdata = r_rdata;

  // RAM write port; contents are not reset, and reset blocks a same-edge accept.
  always_ff @(posedge clk) begin
    if (!rst && w_accept && req_write) begin
      r_mem[req_addr] <= req_wdata;
    end
  end

  // Request/response FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_write <= 1'b0;
      r_rdata      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            if (req_write) begin
              r_resp_write <= 1'b1;
              r_rdata      <= '0;
              r_resp_valid <= 1'b1;
              r_state      <= S_RESP;
            end else begin
              r_resp_write <= 1'b0;
              r_rdata      <= r_mem[req_addr];
              if (READ_LATENCY == 1) begin
                r_resp_valid <= 1'b1;
                r_state      <= S_RESP;
              end else begin
                r_cnt   <= C_LAT_M1;
                r_state <= S_WAIT;
              end
            end
          end
        end
        S_WAIT: begin
          if (r_cnt == C_CNT_W'(1)) begin
            r_cnt        <= '0;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_cnt <= r_cnt - C_CNT_W'(1);
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state      <= S_IDLE;
          r_cnt        <= '0;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/ram_responder.md
Name: ram_responder

Overview:
- Memory-side responder for the `read_write_ram` initiator's request/response handshake.
- Owns a DEPTH-word synchronous RAM and services one read or write request at a time.
- Returns exactly one in-order response per accepted request, with a fixed read latency and full response backpressure.
- Sits between RAM-driving control blocks and their backing storage.

Parameters:
- ADDR_WIDTH, 4: address bits; DEPTH = 2**ADDR_WIDTH words, so no out-of-range addresses exist.
- DATA_WIDTH, 32: word width.
- READ_LATENCY, 2: cycles from read accept to resp_valid. Legal range 1..8; outside this range is a configuration error, flagged at elaboration.

Ports:
- clk  in  1  rising-edge clock; the only clock domain.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator takes the response.
- resp_write  out  1  response is a write ack (1) or read data (0).
- resp_rdata  out  DATA_WIDTH  read data; 0 for write acks.
- busy  out  1  request outstanding; equals ~req_ready.

Behaviour:
- Clock and reset: single clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=IDLE, req_ready=1, busy=0, resp_valid=0, resp_write=0, resp_rdata=0, latency counter=0.
  - RAM contents are NOT reset; they are undefined until written.
- Accept: occurs on a rising edge where req_valid && req_ready. Request fields are sampled only at accept.
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1, resp_valid=0.
  - Accepted write: mem[req_addr] <= req_wdata at the accept edge. Next state RESP with resp_write=1, resp_rdata=0. The ack is visible in the cycle after accept.
  - Accepted read: data register <= mem[req_addr] at the accept edge.
    - If READ_LATENCY==1: next state RESP.
    - Otherwise: next state WAIT with cnt=READ_LATENCY-1.
- WAIT: req_ready=0, resp_valid=0. cnt decrements each cycle. When cnt==1, next state is RESP.
  - Net effect: resp_valid first asserts exactly READ_LATENCY cycles after the accept edge.
- RESP: resp_valid=1, req_ready=0.
  - resp_write and resp_rdata are held stable while resp_ready=0, for any number of cycles.
  - On an edge with resp_ready=1: next state IDLE, resp_valid deasserts.
  - No same-cycle re-accept in RESP. Peak throughput is one write per 2 cycles and one read per READ_LATENCY+1 cycles.
- Ordering and hazards: only one request is outstanding, so there are no read-after-write hazards. A read after a completed write returns the written data.
- req_valid while req_ready=0 is ignored. The initiator must hold the request; its fields may change freely.
- resp_ready while resp_valid=0 is ignored.
- Reset mid-operation: rst in WAIT or RESP discards the in-flight response.
  - The cycle after the reset edge shows reset values.
  - A write accepted before reset remains committed in the RAM.
- rst has priority over a simultaneous accept; that request is not performed.

Test Plan:
- Reset: rst=1 for 1 edge -> next cycle req_ready=1, busy=0, resp_valid=0, resp_rdata=0.
- Write then read (READ_LATENCY=2):
  - Write addr 3, data 0xDEADBEEF -> resp_valid=1, resp_write=1, resp_rdata=0 one cycle after accept.
  - Read addr 3 -> resp_valid rises exactly 2 cycles after accept, resp_rdata=0xDEADBEEF, resp_write=0.
- Backpressure: read addr 3 with resp_ready=0 for 5 cycles -> resp_valid and resp_rdata=0xDEADBEEF stable all 5 cycles; req_ready=0; a req_valid pulse meanwhile is not accepted. Raising resp_ready returns the block to IDLE next cycle.
- Back-to-back: 16 writes (mem[i]=i*0x11) then 16 reads with resp_ready=1 and req_valid=1 continuously -> writes accepted every 2 cycles, reads every 3 cycles; all read data match.
- Reset mid-op: rst asserted in WAIT of a read of addr 5 -> no response ever emitted; req_ready=1 next cycle. A subsequent read of addr 5 returns the value written before reset.
- Latency sweep: READ_LATENCY=1 and 8 -> read response appears exactly 1 or 8 cycles after accept; write ack is still 1 cycle in both.
